// File: rtl/instr_mem_loadable.sv
// Loadable instruction store: byte-serial program loader plus a registered fetch port.
// Words not written since the last load start or reset read back as zero (NOP).
module instr_mem_loadable #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_start,
  input  logic                ld_done,
  input  logic                ld_valid,
  input  logic [7:0]          ld_byte,
  output logic                ld_ready,
  output logic                loading,
  output logic [ADDR_W:0]     ld_words,
  output logic                ld_partial,
  input  logic                fetch_req,
  input  logic [ADDR_W-1:0]   fetch_addr,
  output logic [DATA_W-1:0]   instr,
  output logic                instr_valid,
  output logic                addr_err
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WC_W  = ADDR_W + 1;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_asm;
  logic [WC_W-1:0]     r_ld_words;
  logic                r_ld_partial;
  logic [DEPTH-1:0]    r_bitmap;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_instr;
  logic                r_instr_valid;
  logic                r_addr_err;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [DATA_W-1:0]   w_asm_nxt;
  logic                w_word_done;
  logic                w_partial_set;
  logic [IDX_W-1:0]    w_wr_idx;
  logic [IDX_W-1:0]    w_rd_idx;
  logic                w_in_range;

  assign w_wr_idx   = IDX_W'(r_ld_words);
  assign w_rd_idx   = IDX_W'(fetch_addr);
  assign w_in_range = ({1'b0, fetch_addr} < WC_W'(DEPTH));

  // Next-state and loader control; ld_start overrides everything, auto-exit on the last word
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_asm_nxt     = r_asm;
    w_word_done   = 1'b0;
    w_partial_set = 1'b0;
    if (ld_start) begin
      w_state_nxt = LOAD;
      w_cnt_nxt   = '0;
    end else if (r_state == LOAD) begin
      if (ld_valid) begin
        w_asm_nxt = (r_asm << 8) | DATA_W'(ld_byte);
        if (r_cnt == CNT_W'(BYTES - 1)) begin
          w_word_done = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
        end
      end
      if (w_word_done && (r_ld_words == WC_W'(DEPTH - 1))) begin
        w_state_nxt = RUN;
      end else if (ld_done) begin
        w_state_nxt   = RUN;
        w_partial_set = (w_cnt_nxt != '0);
      end
    end
  end

  // State, byte assembly, word count and written-bitmap registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_cnt        <= '0;
      r_asm        <= '0;
      r_ld_words   <= '0;
      r_ld_partial <= 1'b0;
      r_bitmap     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_asm   <= w_asm_nxt;
      if (ld_start) begin
        r_ld_words   <= '0;
        r_ld_partial <= 1'b0;
        r_bitmap     <= '0;
      end else begin
        if (w_word_done) begin
          r_ld_words         <= WC_W'(r_ld_words + 1'b1);
          r_bitmap[w_wr_idx] <= 1'b1;
        end
        if (w_partial_set) begin
          r_ld_partial <= 1'b1;
        end
      end
    end
  end

  // Instruction array write; contents survive reset, validity lives in the bitmap
  always_ff @(posedge clk) begin
    if (w_word_done && !rst) begin
      r_mem[w_wr_idx] <= w_asm_nxt;
    end
  end

  // Registered fetch port, only serviced in RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_addr_err    <= 1'b0;
    end else if ((r_state == RUN) && fetch_req) begin
      r_instr_valid <= 1'b1;
      if (w_in_range) begin
        r_instr    <= r_bitmap[w_rd_idx] ? r_mem[w_rd_idx] : '0;
        r_addr_err <= 1'b0;
      end else begin
        r_instr    <= '0;
        r_addr_err <= 1'b1;
      end
    end else begin
      r_instr_valid <= 1'b0;
      r_addr_err    <= 1'b0;
    end
  end

  assign ld_ready    = (r_state == LOAD);
  assign loading     = (r_state == LOAD);
  assign ld_words    = r_ld_words;
  assign ld_partial  = r_ld_partial;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign addr_err    = r_addr_err;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: three instances (DEPTH 32, 4, 20), fetch responses
// checked by a scoreboard monitor, loader status checked directly.
module tb_instr_mem_loadable;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_start    [3];
  logic        ld_done     [3];
  logic        ld_valid    [3];
  logic [7:0]  ld_byte     [3];
  logic        ld_ready    [3];
  logic        loading     [3];
  logic [5:0]  ld_words    [3];
  logic        ld_partial  [3];
  logic        fetch_req   [3];
  logic [4:0]  fetch_addr  [3];
  logic [31:0] instr       [3];
  logic        instr_valid [3];
  logic        addr_err    [3];

  typedef struct packed {
    logic [1:0]  dut;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  instr_mem_loadable #(.DATA_W(32), .ADDR_W(5), .DEPTH(32)) u0 (
    .clk(clk), .rst(rst), .ld_start(ld_start[0]), .ld_done(ld_done[0]),
    .ld_valid(ld_valid[0]), .ld_byte(ld_byte[0]), .ld_ready(ld_ready[0]),
    .loading(loading[0]), .ld_words(ld_words[0]), .ld_partial(ld_partial[0]),
    .fetch_req(fetch_req[0]), .fetch_addr(fetch_addr[0]), .instr(instr[0]),
    .instr_valid(instr_valid[0]), .addr_err(addr_err[0]));

  instr_mem_loadable #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .ld_start(ld_start[1]), .ld_done(ld_done[1]),
    .ld_valid(ld_valid[1]), .ld_byte(ld_byte[1]), .ld_ready(ld_ready[1]),
    .loading(loading[1]), .ld_words(ld_words[1]), .ld_partial(ld_partial[1]),
    .fetch_req(fetch_req[1]), .fetch_addr(fetch_addr[1]), .instr(instr[1]),
    .instr_valid(instr_valid[1]), .addr_err(addr_err[1]));

  instr_mem_loadable #(.DATA_W(32), .ADDR_W(5), .DEPTH(20)) u2 (
    .clk(clk), .rst(rst), .ld_start(ld_start[2]), .ld_done(ld_done[2]),
    .ld_valid(ld_valid[2]), .ld_byte(ld_byte[2]), .ld_ready(ld_ready[2]),
    .loading(loading[2]), .ld_words(ld_words[2]), .ld_partial(ld_partial[2]),
    .fetch_req(fetch_req[2]), .fetch_addr(fetch_addr[2]), .instr(instr[2]),
    .instr_valid(instr_valid[2]), .addr_err(addr_err[2]));

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented fetch response is matched against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (instr_valid[d] === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch dut%0d: got instr %h with nothing expected", d, instr[d]);
        end else begin
          e = sb.pop_front();
          check($sformatf("fetch_dut%0d_src", d), 32'(d), 32'(e.dut));
          check($sformatf("fetch_dut%0d_instr", d), instr[d], e.instr);
          check($sformatf("fetch_dut%0d_err", d), 32'(addr_err[d]), 32'(e.err));
        end
      end else if (addr_err[d] !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL addr_err_without_valid dut%0d: got %b expected 0", d, addr_err[d]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(int d, logic [7:0] b);
    ld_valid[d] = 1'b1;
    ld_byte[d]  = b;
    cyc();
    ld_valid[d] = 1'b0;
  endtask

  task automatic put_word(int d, logic [31:0] w);
    for (int i = 0; i < 4; i++) put_byte(d, w[31-8*i -: 8]);
  endtask

  task automatic pulse_start(int d);
    ld_start[d] = 1'b1;
    cyc();
    ld_start[d] = 1'b0;
  endtask

  task automatic pulse_done(int d);
    ld_done[d] = 1'b1;
    cyc();
    ld_done[d] = 1'b0;
  endtask

  task automatic fetch(int d, logic [4:0] a, logic [31:0] ei, logic ee);
    exp_t e;
    e.dut   = 2'(d);
    e.instr = ei;
    e.err   = ee;
    sb.push_back(e);
    fetch_req[d]  = 1'b1;
    fetch_addr[d] = a;
    cyc();
    fetch_req[d]  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      ld_start[d] = 1'b0; ld_done[d] = 1'b0; ld_valid[d] = 1'b0; ld_byte[d] = 8'h00;
      fetch_req[d] = 1'b0; fetch_addr[d] = 5'd0;
    end
    cyc();
    cyc();
    rst = 1'b0;

    // Reset state
    check("rst_loading", 32'(loading[0]), 32'd0);
    check("rst_ld_ready", 32'(ld_ready[0]), 32'd0);
    check("rst_ld_words", 32'(ld_words[0]), 32'd0);
    check("rst_ld_partial", 32'(ld_partial[0]), 32'd0);
    check("rst_instr", instr[0], 32'h0);
    check("rst_instr_valid", 32'(instr_valid[0]), 32'd0);
    check("rst_addr_err", 32'(addr_err[0]), 32'd0);

    // Unwritten store reads NOP
    for (int a = 0; a < 4; a++) fetch(0, 5'(a), 32'h0, 1'b0);

    // Bytes in RUN are ignored
    put_byte(0, 8'hFF);
    check("run_byte_ignored", 32'(ld_words[0]), 32'd0);

    // Three-word program
    pulse_start(0);
    check("load_loading", 32'(loading[0]), 32'd1);
    check("load_ld_ready", 32'(ld_ready[0]), 32'd1);
    put_word(0, 32'h20010003);
    put_word(0, 32'h20020003);
    put_word(0, 32'h00221818);
    pulse_done(0);
    check("prog3_loading", 32'(loading[0]), 32'd0);
    check("prog3_ld_words", 32'(ld_words[0]), 32'd3);
    check("prog3_partial", 32'(ld_partial[0]), 32'd0);
    fetch(0, 5'd0, 32'h20010003, 1'b0);
    fetch(0, 5'd1, 32'h20020003, 1'b0);
    fetch(0, 5'd2, 32'h00221818, 1'b0);
    fetch(0, 5'd3, 32'h00000000, 1'b0);

    // One word plus two stray bytes: partial flagged, old program invalidated
    pulse_start(0);
    put_word(0, 32'hAABBCCDD);
    put_byte(0, 8'h11);
    put_byte(0, 8'h22);
    pulse_done(0);
    check("part_ld_words", 32'(ld_words[0]), 32'd1);
    check("part_partial", 32'(ld_partial[0]), 32'd1);
    fetch(0, 5'd0, 32'hAABBCCDD, 1'b0);
    fetch(0, 5'd1, 32'h0, 1'b0);
    fetch(0, 5'd2, 32'h0, 1'b0);

    // Final byte accepted in the same cycle as ld_done
    pulse_start(0);
    check("start_clears_partial", 32'(ld_partial[0]), 32'd0);
    put_byte(0, 8'h01);
    put_byte(0, 8'h02);
    put_byte(0, 8'h03);
    ld_done[0] = 1'b1;
    put_byte(0, 8'h04);
    ld_done[0] = 1'b0;
    check("done_byte_loading", 32'(loading[0]), 32'd0);
    check("done_byte_words", 32'(ld_words[0]), 32'd1);
    check("done_byte_partial", 32'(ld_partial[0]), 32'd0);
    fetch(0, 5'd0, 32'h01020304, 1'b0);

    // Restart mid-word, then start+done together (start wins)
    pulse_start(0);
    put_byte(0, 8'h55);
    put_byte(0, 8'h66);
    pulse_start(0);
    check("restart_loading", 32'(loading[0]), 32'd1);
    check("restart_partial", 32'(ld_partial[0]), 32'd0);
    put_word(0, 32'h0A0B0C0D);
    ld_start[0] = 1'b1;
    ld_done[0]  = 1'b1;
    cyc();
    ld_start[0] = 1'b0;
    ld_done[0]  = 1'b0;
    check("start_wins_loading", 32'(loading[0]), 32'd1);
    check("start_wins_words", 32'(ld_words[0]), 32'd0);
    put_word(0, 32'hCAFEF00D);
    pulse_done(0);
    check("restart_words", 32'(ld_words[0]), 32'd1);
    check("restart_partial_end", 32'(ld_partial[0]), 32'd0);
    fetch(0, 5'd0, 32'hCAFEF00D, 1'b0);
    fetch(0, 5'd1, 32'h0, 1'b0);

    // DEPTH=4 auto-exit after 16 bytes
    pulse_start(1);
    for (int i = 0; i < 20; i++) begin
      put_byte(1, 8'(i + 1));
      if (i == 14) check("auto_still_loading", 32'(loading[1]), 32'd1);
      if (i == 15) begin
        check("auto_exit_loading", 32'(loading[1]), 32'd0);
        check("auto_exit_ready", 32'(ld_ready[1]), 32'd0);
        check("auto_exit_words", 32'(ld_words[1]), 32'd4);
      end
    end
    check("auto_words_final", 32'(ld_words[1]), 32'd4);
    check("auto_partial", 32'(ld_partial[1]), 32'd0);
    fetch(1, 5'd0, 32'h01020304, 1'b0);
    fetch(1, 5'd1, 32'h05060708, 1'b0);
    fetch(1, 5'd2, 32'h090A0B0C, 1'b0);
    fetch(1, 5'd3, 32'h0D0E0F10, 1'b0);
    fetch(1, 5'd4, 32'h0, 1'b1);
    fetch(1, 5'd31, 32'h0, 1'b1);

    // DEPTH=20 address range, back-to-back
    fetch(2, 5'd25, 32'h0, 1'b1);
    fetch(2, 5'd3, 32'h0, 1'b0);
    fetch(2, 5'd19, 32'h0, 1'b0);
    fetch(2, 5'd20, 32'h0, 1'b1);

    // Fetch ignored during LOAD, then reset mid-load
    fetch(0, 5'd0, 32'hCAFEF00D, 1'b0);
    pulse_start(0);
    fetch_req[0]  = 1'b1;
    fetch_addr[0] = 5'd0;
    put_byte(0, 8'h12);
    fetch_req[0]  = 1'b0;
    check("load_fetch_valid", 32'(instr_valid[0]), 32'd0);
    check("load_fetch_err", 32'(addr_err[0]), 32'd0);
    check("load_fetch_hold", instr[0], 32'hCAFEF00D);
    put_byte(0, 8'h34);
    put_byte(0, 8'h56);
    put_byte(0, 8'h78);
    put_byte(0, 8'h9A);
    put_byte(0, 8'hBC);
    check("pre_rst_words", 32'(ld_words[0]), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_rst_loading", 32'(loading[0]), 32'd0);
    check("mid_rst_words", 32'(ld_words[0]), 32'd0);
    check("mid_rst_partial", 32'(ld_partial[0]), 32'd0);
    fetch(0, 5'd0, 32'h0, 1'b0);
    fetch(0, 5'd1, 32'h0, 1'b0);

    repeat (3) cyc();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
